// File: rtl/bus_pkg.sv
// Shared types for the cache-to-memory bus arbiter: FSM states, requester IDs
// and the default line width, which follows the `DMEM_LINE macro.
`ifndef DMEM_LINE
`define DMEM_LINE 256
`endif

package bus_pkg;

    localparam int LINE_W_DEF = `DMEM_LINE;
    localparam int ADDR_W_DEF = 64;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_WAIT,
        RESP
    } bus_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

endpackage

// File: rtl/bus_wbuf.sv
// One-entry write-back buffer. A push is accepted only while empty; a pop
// empties it. The two never coincide because pop implies the entry is valid.
module bus_wbuf #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [LINE_W-1:0] push_data,
    input  logic              pop,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [LINE_W-1:0] data
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (pop) begin
            valid_d = 1'b0;
        end
        // A write arriving while the entry is occupied is dropped.
        if (push && !valid_q) begin
            valid_d = 1'b1;
            addr_d  = push_addr;
            data_d  = push_data;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign addr  = addr_q;
    assign data  = data_q;

endmodule

// File: rtl/bus_arb.sv
// Memory bus arbiter between imem fills and dmem fills/write-backs, with a
// one-entry write buffer drained ahead of reads. Define BUS_ARB_RR_EN for
// round-robin read arbitration; otherwise dmem always wins a read tie.
module bus_arb
    import bus_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_rd,
    output logic [LINE_W-1:0] i_data,
    output logic              i_dv,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_rd,
    input  logic [LINE_W-1:0] d_data_in,
    input  logic              d_wr,
    output logic [LINE_W-1:0] d_data_out,
    output logic              d_dv,
    output logic              d_wbusy,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_rd,
    input  logic [LINE_W-1:0] m_data_in,
    input  logic              m_dv,
    output logic [LINE_W-1:0] m_data_out,
    output logic              m_wr
);

    bus_state_e        state_q, state_d;
    req_id_e           gnt_q, gnt_d;
    req_id_e           rd_sel;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [LINE_W-1:0] m_data_out_q, m_data_out_d;
    logic              m_rd_q, m_rd_d;
    logic              m_wr_q, m_wr_d;
    logic [LINE_W-1:0] i_data_q, i_data_d;
    logic [LINE_W-1:0] d_data_out_q, d_data_out_d;
    logic              i_dv_q, i_dv_d;
    logic              d_dv_q, d_dv_d;

    logic              wb_push, wb_pop, wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [LINE_W-1:0] wb_data;

`ifdef BUS_ARB_RR_EN
    req_id_e           last_q, last_d;
`endif

    assign wb_push = d_wr && !wb_valid;

    bus_wbuf #(
        .LINE_W (LINE_W),
        .ADDR_W (ADDR_W)
    ) u_wbuf (
        .clk       (clk),
        .clr_n     (clr_n),
        .push      (wb_push),
        .push_addr (d_addr),
        .push_data (d_data_in),
        .pop       (wb_pop),
        .valid     (wb_valid),
        .addr      (wb_addr),
        .data      (wb_data)
    );

    always_comb begin
`ifdef BUS_ARB_RR_EN
        rd_sel = (d_rd && (!i_rd || last_q == REQ_I)) ? REQ_D : REQ_I;
`else
        rd_sel = d_rd ? REQ_D : REQ_I;
`endif
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        rd_addr_d    = rd_addr_q;
        m_addr_d     = m_addr_q;
        m_data_out_d = m_data_out_q;
        i_data_d     = i_data_q;
        d_data_out_d = d_data_out_q;
        m_rd_d       = 1'b0;
        m_wr_d       = 1'b0;
        i_dv_d       = 1'b0;
        d_dv_d       = 1'b0;
        wb_pop       = 1'b0;
`ifdef BUS_ARB_RR_EN
        last_d       = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (wb_valid) begin
                    state_d      = WR;
                    m_wr_d       = 1'b1;
                    m_addr_d     = wb_addr;
                    m_data_out_d = wb_data;
                    wb_pop       = 1'b1;
                // A write landing in the buffer this edge must drain before any read.
                end else if (!d_wr && (i_rd || d_rd)) begin
                    state_d   = RD_REQ;
                    gnt_d     = rd_sel;
                    rd_addr_d = (rd_sel == REQ_D) ? d_addr : i_addr;
`ifdef BUS_ARB_RR_EN
                    last_d    = rd_sel;
`endif
                end
            end
            WR: begin
                state_d = IDLE;
            end
            RD_REQ: begin
                m_rd_d   = 1'b1;
                m_addr_d = rd_addr_q;
                state_d  = RD_WAIT;
            end
            RD_WAIT: begin
                if (m_dv) begin
                    if (gnt_q == REQ_D) begin
                        d_data_out_d = m_data_in;
                        d_dv_d       = 1'b1;
                    end else begin
                        i_data_d = m_data_in;
                        i_dv_d   = 1'b1;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                // Guard cycle: the requester drops its rd before IDLE looks again.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q      <= IDLE;
            gnt_q        <= REQ_D;
            rd_addr_q    <= '0;
            m_addr_q     <= '0;
            m_data_out_q <= '0;
            m_rd_q       <= 1'b0;
            m_wr_q       <= 1'b0;
            i_data_q     <= '0;
            d_data_out_q <= '0;
            i_dv_q       <= 1'b0;
            d_dv_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rd_addr_q    <= rd_addr_d;
            m_addr_q     <= m_addr_d;
            m_data_out_q <= m_data_out_d;
            m_rd_q       <= m_rd_d;
            m_wr_q       <= m_wr_d;
            i_data_q     <= i_data_d;
            d_data_out_q <= d_data_out_d;
            i_dv_q       <= i_dv_d;
            d_dv_q       <= d_dv_d;
        end
    end

`ifdef BUS_ARB_RR_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            last_q <= REQ_D;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign m_addr     = m_addr_q;
    assign m_data_out = m_data_out_q;
    assign m_rd       = m_rd_q;
    assign m_wr       = m_wr_q;
    assign i_data     = i_data_q;
    assign d_data_out = d_data_out_q;
    assign i_dv       = i_dv_q;
    assign d_dv       = d_dv_q;
    assign d_wbusy    = wb_valid;

endmodule

// File: tb/tb_bus_arb.sv
// Randomized bench for bus_arb: a line memory behind the bus, a golden memory
// image and a read-tie model decide every expected value.
`timescale 1ns/1ps
module tb_bus_arb;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 64;

    logic              clk = 1'b0;
    logic              clr_n;
    logic [ADDR_W-1:0] i_addr, d_addr, m_addr;
    logic              i_rd, d_rd, d_wr, m_dv;
    logic [LINE_W-1:0] i_data, d_data_in, d_data_out, m_data_in, m_data_out;
    logic              i_dv, d_dv, d_wbusy, m_rd, m_wr;

    always #5 clk = ~clk;

    bus_arb #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .i_addr     (i_addr),
        .i_rd       (i_rd),
        .i_data     (i_data),
        .i_dv       (i_dv),
        .d_addr     (d_addr),
        .d_rd       (d_rd),
        .d_data_in  (d_data_in),
        .d_wr       (d_wr),
        .d_data_out (d_data_out),
        .d_dv       (d_dv),
        .d_wbusy    (d_wbusy),
        .m_addr     (m_addr),
        .m_rd       (m_rd),
        .m_data_in  (m_data_in),
        .m_dv       (m_dv),
        .m_data_out (m_data_out),
        .m_wr       (m_wr)
    );

    typedef struct {
        bit                wr;
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] d;
        int                c;
    } bus_ev_t;

    int                n_cmp = 0;
    int                n_bad = 0;
    int                cyc = 0;
    int                mdv_cyc = 0;
    int                mem_delay = 1;
    bit                last_is_d = 1'b1;
    bus_ev_t           bus_q[$];
    logic [LINE_W-1:0] ram  [logic [ADDR_W-1:0]];
    logic [LINE_W-1:0] gold [logic [ADDR_W-1:0]];
    logic [ADDR_W-1:0] pool [8];

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [LINE_W-1:0] ram_rd(input logic [ADDR_W-1:0] a);
        return ram.exists(a) ? ram[a] : '0;
    endfunction

    function automatic logic [LINE_W-1:0] gold_rd(input logic [ADDR_W-1:0] a);
        return gold.exists(a) ? gold[a] : '0;
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int w = 0; w < LINE_W / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Memory model: logs every bus command and answers reads after mem_delay cycles.
    initial begin
        bit                mem_busy;
        int                mem_cnt;
        logic [ADDR_W-1:0] mem_a;
        mem_busy  = 1'b0;
        mem_cnt   = 0;
        mem_a     = '0;
        m_dv      = 1'b0;
        m_data_in = '0;
        forever begin
            @(negedge clk);
            chk("rd_wr_excl", m_rd & m_wr, 1'b0);
            if (m_wr) begin
                bus_q.push_back('{wr: 1'b1, a: m_addr, d: m_data_out, c: cyc});
                ram[m_addr] = m_data_out;
            end
            if (m_rd) begin
                bus_q.push_back('{wr: 1'b0, a: m_addr, d: '0, c: cyc});
                mem_busy = 1'b1;
                mem_a    = m_addr;
                mem_cnt  = mem_delay;
            end
            @(posedge clk);
            #1;
            m_dv = 1'b0;
            if (mem_busy) begin
                if (mem_cnt == 0) begin
                    m_dv      = 1'b1;
                    m_data_in = ram_rd(mem_a);
                    mem_busy  = 1'b0;
                    mdv_cyc   = cyc;
                end else begin
                    mem_cnt--;
                end
            end
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_m_addr"}, m_addr, '0);
        chk({tag, "_m_data_out"}, m_data_out, '0);
        chk({tag, "_i_data"}, i_data, '0);
        chk({tag, "_d_data_out"}, d_data_out, '0);
        chk({tag, "_strobes"}, {m_rd, m_wr, i_dv, d_dv, d_wbusy}, 5'b0);
    endtask

    task automatic do_read(input bit is_d, input logic [ADDR_W-1:0] a);
        int                t0, n0, tdv;
        bit                seen;
        logic [LINE_W-1:0] got;
        @(posedge clk);
        #1;
        n0 = bus_q.size();
        t0 = cyc;
        if (is_d) begin d_addr = a; d_rd = 1'b1; end
        else      begin i_addr = a; i_rd = 1'b1; end
        seen = 1'b0;
        tdv  = 0;
        got  = '0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (is_d ? d_dv : i_dv) begin
                seen = 1'b1;
                tdv  = cyc;
                got  = is_d ? d_data_out : i_data;
            end
        end
        chk("rd_done", seen, 1'b1);
        if (seen) begin
            chk("rd_nbus", bus_q.size(), n0 + 1);
            if (bus_q.size() == n0 + 1) begin
                chk("rd_is_read", bus_q[n0].wr, 1'b0);
                chk("rd_addr", bus_q[n0].a, a);
                chk("rd_latency", bus_q[n0].c, t0 + 2);
            end
            chk("dv_latency", tdv, mdv_cyc + 1);
            chk("rd_data", got, gold_rd(a));
        end
        $display("read  %s addr=%0h seen=%0d data=%0h", is_d ? "d" : "i", a, seen, got);
        @(posedge clk);
        #1;
        if (is_d) d_rd = 1'b0; else i_rd = 1'b0;
        @(negedge clk);
        chk("dv_pulse", is_d ? d_dv : i_dv, 1'b0);
        last_is_d = is_d;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] dat,
                            input bit second, input logic [LINE_W-1:0] dat2);
        int                n0;
        logic [ADDR_W-1:0] a2;
        a2 = a ^ 64'h40;
        @(posedge clk);
        #1;
        n0        = bus_q.size();
        d_addr    = a;
        d_data_in = dat;
        d_wr      = 1'b1;
        @(posedge clk);
        #1;
        d_wr = second;
        if (second) begin d_addr = a2; d_data_in = dat2; end
        @(negedge clk);
        chk("wbusy_rise", d_wbusy, 1'b1);
        chk("m_wr_early", m_wr, 1'b0);
        @(posedge clk);
        #1;
        d_wr = 1'b0;
        @(negedge clk);
        chk("wbusy_fall", d_wbusy, 1'b0);
        chk("m_wr", m_wr, 1'b1);
        chk("m_wr_addr", m_addr, a);
        chk("m_wr_data", m_data_out, dat);
        @(negedge clk);
        chk("m_wr_pulse", m_wr, 1'b0);
        repeat (3) @(negedge clk);
        gold[a] = dat;
        chk("wr_nbus", bus_q.size(), n0 + 1);
        chk("wr_ram", ram_rd(a), dat);
        chk("wr_ignored", ram_rd(a2), gold_rd(a2));
        $display("write addr=%0h second=%0d data=%0h", a, second, dat);
    endtask

    task automatic do_wr_rd(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] dat);
        int                n0, t0;
        bit                seen;
        logic [LINE_W-1:0] got;
        @(posedge clk);
        #1;
        n0        = bus_q.size();
        t0        = cyc;
        d_addr    = a;
        d_data_in = dat;
        d_wr      = 1'b1;
        d_rd      = 1'b1;
        @(posedge clk);
        #1;
        d_wr = 1'b0;
        gold[a] = dat;
        seen = 1'b0;
        got  = '0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (d_dv) begin seen = 1'b1; got = d_data_out; end
        end
        chk("raw_done", seen, 1'b1);
        chk("raw_nbus", bus_q.size(), n0 + 2);
        if (bus_q.size() == n0 + 2) begin
            chk("raw_first_wr", bus_q[n0].wr, 1'b1);
            chk("raw_then_rd", bus_q[n0+1].wr, 1'b0);
            chk("raw_wr_cycle", bus_q[n0].c, t0 + 2);
            chk("raw_rd_addr", bus_q[n0+1].a, a);
        end
        chk("raw_data", got, dat);
        $display("wr+rd addr=%0h seen=%0d data=%0h", a, seen, got);
        @(posedge clk);
        #1;
        d_rd = 1'b0;
        @(negedge clk);
        last_is_d = 1'b1;
    endtask

    task automatic do_both(input logic [ADDR_W-1:0] ai, input logic [ADDR_W-1:0] ad);
        int                n0, ti, td;
        bit                got_i, got_d, first_d;
        logic [LINE_W-1:0] di, dd;
`ifdef BUS_ARB_RR_EN
        first_d = !last_is_d;
`else
        first_d = 1'b1;
`endif
        @(posedge clk);
        #1;
        n0     = bus_q.size();
        i_addr = ai;
        d_addr = ad;
        i_rd   = 1'b1;
        d_rd   = 1'b1;
        got_i  = 1'b0;
        got_d  = 1'b0;
        ti = 0; td = 0; di = '0; dd = '0;
        for (int k = 0; k < 100 && !(got_i && got_d); k++) begin
            @(negedge clk);
            if (i_dv && !got_i) begin got_i = 1'b1; ti = cyc; di = i_data; end
            if (d_dv && !got_d) begin got_d = 1'b1; td = cyc; dd = d_data_out; end
            @(posedge clk);
            #1;
            if (got_i) i_rd = 1'b0;
            if (got_d) d_rd = 1'b0;
        end
        chk("both_done", {got_i, got_d}, 2'b11);
        chk("both_order", first_d ? (td < ti) : (ti < td), 1'b1);
        chk("both_nbus", bus_q.size(), n0 + 2);
        if (bus_q.size() == n0 + 2) begin
            chk("both_first_addr", bus_q[n0].a, first_d ? ad : ai);
            chk("both_second_addr", bus_q[n0+1].a, first_d ? ai : ad);
        end
        chk("both_i_data", di, gold_rd(ai));
        chk("both_d_data", dd, gold_rd(ad));
        $display("both  i=%0h d=%0h first=%s ti=%0d td=%0d", ai, ad, first_d ? "d" : "i", ti, td);
        i_rd = 1'b0;
        d_rd = 1'b0;
        @(negedge clk);
        last_is_d = !first_d;
    endtask

    task automatic do_reset_mid(input logic [ADDR_W-1:0] a);
        bit seen;
        mem_delay = 6;
        @(posedge clk);
        #1;
        i_addr = a;
        i_rd   = 1'b1;
        seen   = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (m_rd) seen = 1'b1;
        end
        chk("rst_m_rd_seen", seen, 1'b1);
        @(posedge clk);
        #1;
        clr_n = 1'b0;
        i_rd  = 1'b0;
        @(negedge clk);
        chk_outputs_zero("rst_mid");
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rst_no_dv", {i_dv, d_dv}, 2'b00);
        end
        $display("reset during RD_WAIT addr=%0h", a);
        last_is_d = 1'b1;
        mem_delay = 1;
    endtask

    initial begin
        logic [LINE_W-1:0] v;
        logic [LINE_W-1:0] ff_line;
        logic [LINE_W-1:0] aa_line;
        int                op, p, q;
        clr_n     = 1'b0;
        i_addr    = '0;
        i_rd      = 1'b0;
        d_addr    = '0;
        d_rd      = 1'b0;
        d_data_in = '0;
        d_wr      = 1'b0;
        pool[0] = 64'h0;
        pool[1] = 64'h1000;
        pool[2] = 64'h2000;
        for (int k = 3; k < 8; k++) pool[k] = {$urandom, $urandom} & ~64'hfff | (64'(k) << 8);
        for (int k = 0; k < 8; k++) begin
            v = rand_line();
            ram[pool[k]]  = v;
            gold[pool[k]] = v;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk);
        #1;
        clr_n = 1'b1;

        mem_delay = 3;
        do_read(1'b0, 64'h1000);
        ff_line = rand_line();
        ff_line[7:0] = 8'hFF;
        aa_line = '0;
        aa_line[7:0] = 8'hAA;
        do_write(64'h0, ff_line, 1'b0, aa_line);
        ff_line = rand_line();
        ff_line[7:0] = 8'hFF;
        do_write(64'h0, ff_line, 1'b1, aa_line);
        do_wr_rd(64'h0, ff_line);
        mem_delay = 2;
        do_both(64'h1000, 64'h2000);
        do_reset_mid(64'h1000);
        do_read(1'b1, 64'h2000);

        for (int it = 0; it < 40; it++) begin
            op        = $urandom_range(0, 4);
            mem_delay = $urandom_range(0, 4);
            p         = $urandom_range(0, 7);
            q         = (p + $urandom_range(1, 7)) % 8;
            case (op)
                0: do_read(1'b0, pool[p]);
                1: do_read(1'b1, pool[p]);
                2: do_write(pool[p], rand_line(), $urandom_range(0, 1) == 1, rand_line());
                3: do_wr_rd(pool[p], rand_line());
                default: do_both(pool[p], pool[q]);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
